edid_ddc_responder: RTL and testbench

// I2C/DDC target that answers EDID reads from the upstream HDMI source on the

---
 rtl/edid_ddc_responder.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_edid_ddc_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edid_ddc_responder.sv
`default_nettype none
// ============================================================================
// Module   : edid_ddc_responder
// Brief    : Open-drain I2C/DDC target serving EDID bytes from an external ROM.
// Revision : 1.0
// ============================================================================
module edid_ddc_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         FILTER_LEN = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       scl_oe,
  output logic       sda_out,
  output logic       sda_oe,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       busy
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] c_run_max = CW'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_ADDR_ACK = 4'd2,
    S_WR_OFF   = 4'd3,
    S_WR_ACK   = 4'd4,
    S_WR_DATA  = 4'd5,
    S_RD_BYTE  = 4'd6,
    S_RD_ACK   = 4'd7,
    S_IGNORE   = 4'd8
  } state_t;

  logic [1:0] w_pad;
  logic [1:0] w_lvl;
  logic [1:0] w_lvl_d;

  assign w_pad = {sda_in, scl_in};

  // Index 0 is SCL, index 1 is SDA; a level is accepted only after a full run.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filt
      logic          r_s1;
      logic          r_s2;
      logic          r_lvl;
      logic          r_lvl_d;
      logic [CW-1:0] r_run;

      always_ff @(posedge sys_clk) begin
        if (rst) begin
          r_s1    <= 1'b1;
          r_s2    <= 1'b1;
          r_lvl   <= 1'b1;
          r_lvl_d <= 1'b1;
          r_run   <= '0;
        end else begin
          r_s1    <= w_pad[gi];
          r_s2    <= r_s1;
          r_lvl_d <= r_lvl;
          if (r_s2 == r_lvl) begin
            r_run <= '0;
          end else if (r_run == c_run_max) begin
            r_lvl <= r_s2;
            r_run <= '0;
          end else begin
            r_run <= r_run + CW'(1);
          end
        end
      end

      assign w_lvl[gi]   = r_lvl;
      assign w_lvl_d[gi] = r_lvl_d;
    end
  endgenerate

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl      = w_lvl[0];
  assign w_sda      = w_lvl[1];
  assign w_scl_rise =  w_lvl[0] & ~w_lvl_d[0];
  assign w_scl_fall = ~w_lvl[0] &  w_lvl_d[0];
  assign w_start    = w_scl & ~w_lvl[1] &  w_lvl_d[1];
  assign w_stop     = w_scl &  w_lvl[1] & ~w_lvl_d[1];

  state_t     r_state,    w_state_nxt;
  logic [2:0] r_bitcnt,   w_bitcnt_nxt;
  logic [7:0] r_shift,    w_shift_nxt;
  logic [7:0] r_tx,       w_tx_nxt;
  logic [7:0] r_offset,   w_offset_nxt;
  logic [7:0] r_rom_addr, w_rom_addr_nxt;
  logic [1:0] r_fetch,    w_fetch_nxt;
  logic       r_sda_oe,   w_sda_oe_nxt;
  logic       r_busy,     w_busy_nxt;
  logic       r_ack_drv,  w_ack_drv_nxt;
  logic       r_rw,       w_rw_nxt;
  logic [7:0] w_shift_in;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_offset   <= '0;
      r_rom_addr <= '0;
      r_fetch    <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_ack_drv  <= 1'b0;
      r_rw       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_offset   <= w_offset_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_fetch    <= w_fetch_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_ack_drv  <= w_ack_drv_nxt;
      r_rw       <= w_rw_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_offset_nxt   = r_offset;
    w_rom_addr_nxt = r_rom_addr;
    w_fetch_nxt    = {r_fetch[0], 1'b0};
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_ack_drv_nxt  = r_ack_drv;
    w_rw_nxt       = r_rw;
    w_shift_in     = {r_shift[6:0], w_sda};

    // ROM data lands two cycles after the address register updates.
    if (r_fetch[1]) begin
      w_tx_nxt = rom_data;
    end

    if (w_start) begin
      w_state_nxt   = S_ADDR;
      w_bitcnt_nxt  = '0;
      w_shift_nxt   = '0;
      w_sda_oe_nxt  = 1'b0;
      w_ack_drv_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
        end
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_shift_in;
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (w_shift_in[7:1] == DEV_ADDR) begin
                w_state_nxt   = S_ADDR_ACK;
                w_busy_nxt    = 1'b1;
                w_ack_drv_nxt = 1'b0;
                w_rw_nxt      = w_shift_in[0];
                if (w_shift_in[0]) begin
                  w_rom_addr_nxt = r_offset;
                  w_fetch_nxt    = 2'b01;
                end
              end else begin
                w_state_nxt = S_IGNORE;
                w_busy_nxt  = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_drv) begin
              w_sda_oe_nxt  = 1'b1;
              w_ack_drv_nxt = 1'b1;
            end else if (r_rw) begin
              w_sda_oe_nxt = ~r_tx[7];
              w_tx_nxt     = {r_tx[6:0], 1'b0};
              w_bitcnt_nxt = 3'd1;
              w_state_nxt  = S_RD_BYTE;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_bitcnt_nxt = '0;
              w_state_nxt  = S_WR_OFF;
            end
          end
        end
        S_WR_OFF, S_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_shift_in;
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_state_nxt   = S_WR_ACK;
              w_ack_drv_nxt = 1'b0;
              if (r_state == S_WR_OFF) begin
                w_offset_nxt = w_shift_in;
              end
            end
          end
        end
        S_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_drv) begin
              w_sda_oe_nxt  = 1'b1;
              w_ack_drv_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_bitcnt_nxt = '0;
              w_state_nxt  = S_WR_DATA;
            end
          end
        end
        S_RD_BYTE: begin
          if (w_scl_fall) begin
            if (r_bitcnt == 3'd0) begin
              w_sda_oe_nxt  = 1'b0;
              w_ack_drv_nxt = 1'b0;
              w_state_nxt   = S_RD_ACK;
            end else begin
              w_sda_oe_nxt = ~r_tx[7];
              w_tx_nxt     = {r_tx[6:0], 1'b0};
              w_bitcnt_nxt = r_bitcnt + 3'd1;
            end
          end
        end
        S_RD_ACK: begin
          // r_ack_drv here marks that the host ACKed and the next byte is due.
          if (w_scl_rise) begin
            if (w_sda) begin
              w_state_nxt = S_IGNORE;
              w_busy_nxt  = 1'b0;
            end else begin
              w_offset_nxt   = r_offset + 8'd1;
              w_rom_addr_nxt = r_offset + 8'd1;
              w_fetch_nxt    = 2'b01;
              w_ack_drv_nxt  = 1'b1;
            end
          end else if (w_scl_fall && r_ack_drv) begin
            w_sda_oe_nxt = ~r_tx[7];
            w_tx_nxt     = {r_tx[6:0], 1'b0};
            w_bitcnt_nxt = 3'd1;
            w_state_nxt  = S_RD_BYTE;
          end
        end
        S_IGNORE: begin
          w_sda_oe_nxt = 1'b0;
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  assign scl_out  = 1'b0;
  assign scl_oe   = 1'b0;
  assign sda_out  = 1'b0;
  assign sda_oe   = r_sda_oe;
  assign rom_addr = r_rom_addr;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_edid_ddc_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_edid_ddc_responder
// Brief    : Directed bus-master bench for edid_ddc_responder with ROM model.
// Revision : 1.0
// ============================================================================
module tb_edid_ddc_responder;

  localparam int Q = 20;
  localparam int H = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       sda_bus;
  logic       scl_out, scl_oe, sda_out, sda_oe, busy;
  logic [7:0] rom_addr;
  logic [7:0] rom_q;
  logic [7:0] rom [256];

  int checks   = 0;
  int failures = 0;
  int oe_viol  = 0;
  int busy_cyc = 0;
  int oe_cyc   = 0;
  logic prev_oe = 1'b0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign sda_bus = m_sda & ~sda_oe;

  edid_ddc_responder #(.DEV_ADDR(7'h50), .FILTER_LEN(4)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .scl_in  (m_scl),
    .sda_in  (sda_bus),
    .scl_out (scl_out),
    .scl_oe  (scl_oe),
    .sda_out (sda_out),
    .sda_oe  (sda_oe),
    .rom_addr(rom_addr),
    .rom_data(rom_q),
    .busy    (busy)
  );

  always @(posedge clk) rom_q <= rom[rom_addr];

  always @(posedge clk) begin
    prev_oe <= sda_oe;
    if (sda_oe !== prev_oe && m_scl === 1'b1) oe_viol <= oe_viol + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (sda_oe) oe_cyc <= oe_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b0; wait_clk(H); m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1; wait_clk(Q); m_scl = 1'b1; wait_clk(H);
    m_sda = 1'b0; wait_clk(H); m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clk(Q); m_scl = 1'b1; wait_clk(H); m_sda = 1'b1; wait_clk(H);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; wait_clk(Q); m_scl = 1'b1; wait_clk(H); m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic get_bit(output logic b, input bit glitch);
    m_sda = 1'b1;
    if (glitch) begin
      wait_clk(6); m_scl = 1'b1; wait_clk(2); m_scl = 1'b0; wait_clk(Q - 8);
    end else begin
      wait_clk(Q);
    end
    m_scl = 1'b1; wait_clk(H / 2); b = sda_bus; wait_clk(H / 2);
    if (glitch) begin
      m_scl = 1'b0; wait_clk(2); m_scl = 1'b1; wait_clk(6);
    end
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack, 1'b0);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack, input bit glitch);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b, glitch);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;
    int         bc;
    int         oc;

    for (int i = 0; i < 256; i++) rom[i] = 8'((i * 37 + 11) ^ 8'h5A);
    rom[8'h30] = 8'h00;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    wait_clk(5);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_rom_addr", rom_addr, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_scl_oe", scl_oe, 1'b0);
    chk("rst_scl_out", scl_out, 1'b0);
    chk("rst_sda_out", sda_out, 1'b0);
    rst = 1'b0;
    wait_clk(10);

    // Offset 0x10 write, repeated START, read three bytes.
    bus_start();
    put_byte(8'hA0, ack); chk("t1_ack_addr_w", ack, 1'b0);
    put_byte(8'h10, ack); chk("t1_ack_offset", ack, 1'b0);
    bus_rstart();
    put_byte(8'hA1, ack); chk("t1_ack_addr_r", ack, 1'b0);
    chk("t1_busy_on", busy, 1'b1);
    for (int i = 0; i < 3; i++) exp_q.push_back(rom[8'h10 + i]);
    for (int i = 0; i < 3; i++) begin
      get_byte(d, (i == 2) ? 1'b1 : 1'b0, 1'b0);
      chk($sformatf("t1_data%0d", i), d, exp_q.pop_front());
    end
    chk("t1_busy_off", busy, 1'b0);
    bus_stop();

    // Foreign address: no ACK, no busy, no drive.
    bc = busy_cyc; oc = oe_cyc;
    bus_start();
    put_byte(8'hA2, ack); chk("t2_nack_addr", ack, 1'b1);
    put_byte(8'h00, ack); chk("t2_nack_data", ack, 1'b1);
    bus_stop();
    chk("t2_busy_never", busy_cyc - bc, 0);
    chk("t2_oe_never", oe_cyc - oc, 0);

    // Wrap from 0xFE.
    bus_start();
    put_byte(8'hA0, ack); chk("t3_ack_addr_w", ack, 1'b0);
    put_byte(8'hFE, ack); chk("t3_ack_offset", ack, 1'b0);
    bus_rstart();
    put_byte(8'hA1, ack); chk("t3_ack_addr_r", ack, 1'b0);
    exp_q.push_back(rom[8'hFE]); exp_q.push_back(rom[8'hFF]);
    exp_q.push_back(rom[8'h00]); exp_q.push_back(rom[8'h01]);
    for (int i = 0; i < 4; i++) begin
      get_byte(d, (i == 3) ? 1'b1 : 1'b0, 1'b0);
      chk($sformatf("t3_data%0d", i), d, exp_q.pop_front());
    end
    chk("t3_rom_addr_wrap", rom_addr, 8'h01);
    bus_stop();

    // SCL glitches during the data phase.
    bus_start();
    put_byte(8'hA0, ack); chk("t4_ack_addr_w", ack, 1'b0);
    put_byte(8'h20, ack); chk("t4_ack_offset", ack, 1'b0);
    bus_rstart();
    put_byte(8'hA1, ack); chk("t4_ack_addr_r", ack, 1'b0);
    exp_q.push_back(rom[8'h20]); exp_q.push_back(rom[8'h21]);
    for (int i = 0; i < 2; i++) begin
      get_byte(d, (i == 1) ? 1'b1 : 1'b0, 1'b1);
      chk($sformatf("t4_data%0d", i), d, exp_q.pop_front());
    end
    bus_stop();

    // Reset during bit 4 of a read byte.
    bus_start();
    put_byte(8'hA0, ack); chk("t5_ack_addr_w", ack, 1'b0);
    put_byte(8'h30, ack); chk("t5_ack_offset", ack, 1'b0);
    bus_rstart();
    put_byte(8'hA1, ack); chk("t5_ack_addr_r", ack, 1'b0);
    for (int i = 0; i < 3; i++) get_bit(b, 1'b0);
    chk("t5_oe_before_rst", sda_oe, 1'b1);
    rst = 1'b1;
    wait_clk(1);
    chk("t5_oe_after_rst", sda_oe, 1'b0);
    chk("t5_busy_after_rst", busy, 1'b0);
    rst = 1'b0;
    wait_clk(10);
    bus_stop();
    bus_start();
    put_byte(8'hA1, ack); chk("t5_ack_read", ack, 1'b0);
    exp_q.push_back(rom[8'h00]);
    get_byte(d, 1'b1, 1'b0);
    chk("t5_data", d, exp_q.pop_front());
    bus_stop();

    // STOP after 5 offset bits leaves the offset alone.
    bus_start();
    put_byte(8'hA0, ack); chk("t6_ack_addr_w", ack, 1'b0);
    put_byte(8'h40, ack); chk("t6_ack_offset", ack, 1'b0);
    bus_stop();
    bus_start();
    put_byte(8'hA0, ack); chk("t6_ack_addr_w2", ack, 1'b0);
    put_bit(1'b0); put_bit(1'b1); put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
    bus_stop();
    bus_start();
    put_byte(8'hA1, ack); chk("t6_ack_addr_r", ack, 1'b0);
    exp_q.push_back(rom[8'h40]);
    get_byte(d, 1'b1, 1'b0);
    chk("t6_data", d, exp_q.pop_front());
    bus_stop();

    chk("oe_change_scl_high", oe_viol, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
